// File: rtl/inst_rom_responder.sv
// Instruction word responder for the fetch stage: on-chip word array with a host load port
// and WAIT_CYCLES wait states. Defining INST_ROM_MISALIGN_EN adds the misalign output.
module inst_rom_responder #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic [31:0]           pc,
  output logic [31:0]           inst,
  output logic                  inst_valid,
  output logic                  busy,
  input  logic                  load_we,
  input  logic [DEPTH_LOG2-1:0] load_addr,
  input  logic [31:0]           load_data,
  output logic                  load_ready
`ifdef INST_ROM_MISALIGN_EN
  ,
  output logic                  misalign
`endif
);

  localparam int IW = DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic [IW-1:0] idx_q;
  logic          nop_q;
  logic          mis_q;
  logic          pend_q;
  logic          busy_q;
  logic          ready_q;
  logic          valid_q;
  logic          zero_out_q;
  logic          misalign_q;
  logic [31:0]   rd_data_q;
  logic [31:0]   mem [2**IW];

  logic [IW-1:0] idx_d;
  logic          oor_d;
  logic          mis_d;
  logic          nop_d;
  logic          load_acc;
  logic          req;
  logic          capture;
  logic          wait_done;
  logic          rd_en;
  logic [IW-1:0] rd_idx;

  assign idx_d = pc[IW+1:2];
  assign oor_d = (pc[31:IW+2] != '0);

`ifdef INST_ROM_MISALIGN_EN
  assign mis_d    = (pc[1:0] != 2'b00);
  assign misalign = misalign_q;
`else
  logic unused_misalign;
  assign mis_d           = 1'b0;
  assign unused_misalign = misalign_q ^ (^pc[1:0]);
`endif

  assign nop_d     = oor_d | mis_d;
  assign load_acc  = load_we & ready_q;
  // IDLE and RESP are capture points; a held fetch counts as a request
  assign req       = (state_q != WAIT) & (ce | pend_q);
  assign capture   = req & ~load_acc;
  assign wait_done = (state_q == WAIT) && (cnt_q == 4'd1);

  // The array is read on the edge that enters RESP; nop responses skip the read
  assign rd_en  = (WAIT_CYCLES == 0) ? (capture & ~nop_d) : (wait_done & ~nop_q);
  assign rd_idx = (WAIT_CYCLES == 0) ? idx_d : idx_q;

  always_ff @(posedge clk) begin
    if (load_acc) mem[load_addr] <= load_data;
    if (rd_en)    rd_data_q      <= mem[rd_idx];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      idx_q      <= '0;
      nop_q      <= 1'b0;
      mis_q      <= 1'b0;
      pend_q     <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
      zero_out_q <= 1'b1;
      misalign_q <= 1'b0;
    end else begin
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
      case (state_q)
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q    <= RESP;
            valid_q    <= 1'b1;
            zero_out_q <= nop_q;
            misalign_q <= mis_q;
          end else begin
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          pend_q  <= 1'b0;
          if (req && load_acc) begin
            pend_q <= 1'b1;
            busy_q <= 1'b1;
          end else if (capture) begin
            idx_q <= idx_d;
            nop_q <= nop_d;
            mis_q <= mis_d;
            if (WAIT_CYCLES == 0) begin
              state_q    <= RESP;
              valid_q    <= 1'b1;
              zero_out_q <= nop_d;
              misalign_q <= mis_d;
            end else begin
              state_q <= WAIT;
              cnt_q   <= 4'(WAIT_CYCLES);
              busy_q  <= 1'b1;
              ready_q <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign inst       = zero_out_q ? 32'h0 : rd_data_q;
  assign inst_valid = valid_q;
  assign busy       = busy_q;
  assign load_ready = ready_q;

endmodule

// File: tb/tb_inst_rom_responder.sv
// Scoreboard bench for inst_rom_responder: a zero-wait and a three-wait instance share
// random and directed stimulus; a cycle-level reference model predicts every response.
module tb_inst_rom_responder;

  localparam int DL = 10;
  localparam int NW = 16;
`ifdef INST_ROM_MISALIGN_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          ce;
  logic [31:0]   pc;
  logic          load_we;
  logic [DL-1:0] load_addr;
  logic [31:0]   load_data;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  initial forever begin
    @(negedge clk);
    cyc++;
  end

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  typedef struct {
    int          rcyc;
    logic [31:0] data;
    logic        mis;
  } resp_t;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int W = gi * 3;

    logic [31:0] inst;
    logic        inst_valid;
    logic        busy;
    logic        load_ready;
`ifdef INST_ROM_MISALIGN_EN
    logic        misalign;
`endif

    inst_rom_responder #(.DEPTH_LOG2(DL), .WAIT_CYCLES(W)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .ce        (ce),
      .pc        (pc),
      .inst      (inst),
      .inst_valid(inst_valid),
      .busy      (busy),
      .load_we   (load_we),
      .load_addr (load_addr),
      .load_data (load_data),
      .load_ready(load_ready)
`ifdef INST_ROM_MISALIGN_EN
      ,
      .misalign  (misalign)
`endif
    );

    // Reference model: the responder is free unless inside a wait window; loads win
    logic [31:0] mem_m [NW];
    resp_t       q[$];
    int          win_hi   = -1;
    bit          pend     = 1'b0;
    bit          exp_busy = 1'b0;
    bit          exp_lr   = 1'b1;

    initial begin
      bit    in_wait;
      bit    la;
      resp_t r;
      int    k;
      forever begin
        @(posedge clk);
        if (!rst) begin
          q.delete();
          win_hi   = -1;
          pend     = 1'b0;
          exp_busy = 1'b0;
          exp_lr   = 1'b1;
        end else begin
          k       = cyc;
          in_wait = (k <= win_hi);
          la      = load_we && !in_wait;
          if (!in_wait && (ce || pend)) begin
            if (la) begin
              pend = 1'b1;
            end else begin
              pend   = 1'b0;
              r.rcyc = k + 1 + W;
              r.mis  = MIS_EN && (pc[1:0] != 2'b00);
              r.data = ((pc[31:DL+2] != 0) || r.mis) ? 32'h0 : mem_m[pc[5:2]];
              q.push_back(r);
              win_hi = k + W;
            end
          end
          if (la) mem_m[load_addr[3:0]] = load_data;
          exp_busy = (k + 1 <= win_hi) || pend;
          exp_lr   = !(k + 1 <= win_hi);
        end
      end
    end

    initial begin
      resp_t       r;
      int          now;
      logic [31:0] last;
      last = 32'h0;
      forever begin
        @(posedge clk);
        #2;
        now = cyc + 1;
        if (!rst) begin
          last = 32'h0;
          check($sformatf("W%0d reset inst", W), inst, 32'h0);
          check($sformatf("W%0d reset inst_valid", W), {31'b0, inst_valid}, 32'd0);
          check($sformatf("W%0d reset busy", W), {31'b0, busy}, 32'd0);
          check($sformatf("W%0d reset load_ready", W), {31'b0, load_ready}, 32'd1);
        end else begin
          check($sformatf("W%0d busy", W), {31'b0, busy}, {31'b0, exp_busy});
          check($sformatf("W%0d load_ready", W), {31'b0, load_ready}, {31'b0, exp_lr});
          if (inst_valid) begin
            if (q.size() == 0) begin
              check($sformatf("W%0d unexpected inst_valid", W), {31'b0, inst_valid}, 32'd0);
            end else begin
              r = q.pop_front();
              check($sformatf("W%0d response cycle", W), now, r.rcyc);
              check($sformatf("W%0d inst", W), inst, r.data);
`ifdef INST_ROM_MISALIGN_EN
              check($sformatf("W%0d misalign", W), {31'b0, misalign}, {31'b0, r.mis});
`endif
              last = r.data;
              $display("W%0d cycle %0d: inst=%h expected %h", W, now, inst, r.data);
            end
          end else begin
            check($sformatf("W%0d inst hold", W), inst, last);
            if (q.size() > 0 && q[0].rcyc <= now) begin
              check($sformatf("W%0d missing inst_valid", W), {31'b0, inst_valid}, 32'd1);
              void'(q.pop_front());
            end
          end
        end
      end
    end
  end

  task automatic drive(input logic c, input logic [31:0] p, input logic we,
                       input logic [DL-1:0] a, input logic [31:0] d);
    @(negedge clk);
    ce        = c;
    pc        = p;
    load_we   = we;
    load_addr = a;
    load_data = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b0, '0, 32'h0);
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] p;
    p = 32'h0;
    p[5:2] = 4'($urandom_range(0, NW - 1));
    if ($urandom_range(0, 7) == 0) p[1:0] = 2'($urandom_range(1, 3));
    if ($urandom_range(0, 9) == 0) p[31:DL+2] = 20'($urandom_range(1, 20'hFFFFF));
    return p;
  endfunction

  task automatic check_reset_now();
    check("W0 async reset inst", g_dut[0].inst, 32'h0);
    check("W0 async reset inst_valid", {31'b0, g_dut[0].inst_valid}, 32'd0);
    check("W3 async reset inst", g_dut[1].inst, 32'h0);
    check("W3 async reset inst_valid", {31'b0, g_dut[1].inst_valid}, 32'd0);
    check("W3 async reset busy", {31'b0, g_dut[1].busy}, 32'd0);
    check("W3 async reset load_ready", {31'b0, g_dut[1].load_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] init_w [4];
    init_w = '{32'h11, 32'h22, 32'h33, 32'h44};
    rst       = 1'b0;
    ce        = 1'b0;
    pc        = 32'h0;
    load_we   = 1'b0;
    load_addr = '0;
    load_data = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NW; i++)
      drive(1'b0, 32'h0, 1'b1, DL'(i), (i < 4) ? init_w[i] : $urandom());
    idle(2);

    for (int i = 0; i < 4; i++) drive(1'b1, 32'(i * 4), 1'b0, '0, 32'h0);
    idle(6);

    drive(1'b1, 32'h8, 1'b0, '0, 32'h0);
    idle(6);

    drive(1'b1, 32'h8, 1'b1, DL'(2), 32'hAA);
    drive(1'b0, 32'h8, 1'b0, '0, 32'h0);
    idle(6);

    drive(1'b1, 32'h0000_1000, 1'b0, '0, 32'h0);
    idle(6);

    drive(1'b1, 32'h6, 1'b0, '0, 32'h0);
    idle(6);

    for (int i = 0; i < 400; i++)
      drive(1'($urandom_range(0, 1)), rand_pc(), ($urandom_range(0, 4) == 0),
            DL'($urandom_range(0, NW - 1)), $urandom());
    idle(8);

    drive(1'b1, 32'h4, 1'b0, '0, 32'h0);
    drive(1'b0, 32'h0, 1'b0, '0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_now();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle(8);

    check("W0 outstanding responses", g_dut[0].q.size(), 32'd0);
    check("W3 outstanding responses", g_dut[1].q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
